// File: rtl/clocked_sram.sv
// clocked_sram: clock-sampled CY6264-style SRAM emulation with cycle-counted access timing and a boot load port
module clocked_sram #(
  parameter int    ADDR_WIDTH  = 13,
  parameter int    DATA_WIDTH  = 8,
  parameter string INIT_FILE   = "",
  parameter int    SYNC_STAGES = 2,
  parameter int    tACE_CYC    = 3,
  parameter int    tAA_CYC     = 3,
  parameter int    tOHA_CYC    = 1,
  parameter int    tDOE_CYC    = 2,
  parameter int    tLZOE_CYC   = 1,
  parameter int    tHZ_CYC     = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  nCE,
  input  logic                  nOE,
  input  logic                  nWE,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D_IN,
  output logic [DATA_WIDTH-1:0] D_OUT,
  output logic                  D_OE,
  output logic                  D_VALID,
  input  logic                  LD_VALID,
  output logic                  LD_READY,
  input  logic [ADDR_WIDTH-1:0] LD_ADDR,
  input  logic [DATA_WIDTH-1:0] LD_DATA
);
  function automatic int pmax(input int x, input int y);
    return x > y ? x : y;
  endfunction
  localparam int CW = $clog2(pmax(pmax(pmax(tACE_CYC, tAA_CYC), pmax(tOHA_CYC, tDOE_CYC)),
                                  pmax(tLZOE_CYC, tHZ_CYC)) + 2);
  localparam int SW = 3 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [SW-1:0] IDLE_V = {3'b111, {(SW-3){1'b0}}};
  typedef enum logic [1:0] {HIZ, LOWZ, VALID, HOLD} state_t;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [SW-1:0] raw, s;
  logic nce, noe, nwe, rd, wact, ok, ld_fire;
  logic [ADDR_WIDTH-1:0] a, a_q, wa_q, wa_d;
  logic [DATA_WIDTH-1:0] din, wd_q, wd_d, dout_q, dout_d, rdata;
  logic [CW-1:0] ce_q, ce_d, oe_q, oe_d, aa_q, aa_d, hz_q, hz_d;
  logic wact_q, pend_q, pend_d, ld_ready_q, ld_ready_d;
  state_t state_q, state_d, end_st;
  assign raw = {nCE, nOE, nWE, A, D_IN};
  generate
    if (SYNC_STAGES == 0) begin : g_raw
      assign s = raw;
    end else begin : g_sync
      logic [SYNC_STAGES*SW-1:0] sync_q;
      always_ff @(posedge CLK)
        sync_q <= !nRST ? {SYNC_STAGES{IDLE_V}} : (SYNC_STAGES*SW)'({sync_q, raw});
      assign s = sync_q[SYNC_STAGES*SW-1 -: SW];
    end
  endgenerate
  assign {nce, noe, nwe, a, din} = s;
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  always_comb begin
    ce_d = nce ? '0 : inc(ce_q);
    oe_d = noe ? '0 : inc(oe_q);
    aa_d = a == a_q ? inc(aa_q) : CW'(1);
    rd = !nce && nwe && !noe;
    wact = !nce && !nwe;
    ok = ce_d >= CW'(tACE_CYC) && oe_d >= CW'(tDOE_CYC) && aa_d >= CW'(tAA_CYC);
    rdata = pend_q && wa_q == a ? wd_q : mem[a];
    end_st = tHZ_CYC == 0 ? HIZ : HOLD;
    hz_d = '0;
    dout_d = dout_q;
    state_d = state_q;
    case (state_q)
      HIZ: state_d = rd && oe_d >= CW'(tLZOE_CYC) ? LOWZ : HIZ;
      LOWZ: begin
        state_d = !rd ? end_st : ok ? VALID : LOWZ;
        dout_d = rdata;
      end
      VALID: begin
        state_d = !rd ? end_st : aa_d > CW'(tOHA_CYC) && aa_d < CW'(tAA_CYC) ? LOWZ : VALID;
        dout_d = aa_d == CW'(tOHA_CYC + 1) ? rdata : dout_q;
      end
      default: begin
        hz_d = inc(hz_q);
        state_d = rd ? LOWZ : hz_d >= CW'(tHZ_CYC) ? HIZ : HOLD;
      end
    endcase
    state_d = nwe ? state_d : HIZ;
    dout_d = state_d == VALID ? dout_d : '0;
    wa_d = wact ? a : wa_q;
    wd_d = wact ? din : wd_q;
    pend_d = wact_q && !wact;
    ld_ready_d = nce && !pend_d;
    ld_fire = LD_VALID && ld_ready_q;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= HIZ;
      ce_q <= '0;
      oe_q <= '0;
      aa_q <= '0;
      hz_q <= '0;
      a_q <= '0;
      dout_q <= '0;
      wact_q <= 1'b0;
      pend_q <= 1'b0;
      ld_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q <= ce_d;
      oe_q <= oe_d;
      aa_q <= aa_d;
      hz_q <= hz_d;
      a_q <= a;
      dout_q <= dout_d;
      wact_q <= wact;
      pend_q <= pend_d;
      ld_ready_q <= ld_ready_d;
    end
    wa_q <= wa_d;
    wd_q <= wd_d;
  end
  always_ff @(posedge CLK)
    if (nRST && pend_q) mem[wa_q] <= wd_q;
    else if (nRST && ld_fire) mem[LD_ADDR] <= LD_DATA;
  initial
    for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
  assign D_OUT = dout_q;
  assign D_OE = state_q != HIZ;
  assign D_VALID = state_q == VALID;
  assign LD_READY = ld_ready_q;
endmodule

// File: tb/tb_clocked_sram.sv
// tb_clocked_sram: randomized scoreboard bench for clocked_sram against an array memory model
module tb_clocked_sram;
  localparam int AW = 6;
  localparam int DW = 8;
  logic CLK = 0, nRST = 0, nCE = 1, nOE = 1, nWE = 1, LD_VALID = 0;
  logic [AW-1:0] A = '0, LD_ADDR = '0;
  logic [DW-1:0] D_IN = '0, LD_DATA = '0;
  logic [DW-1:0] D_OUT;
  logic D_OE, D_VALID, LD_READY;
  int total = 0, bad = 0, cyc = 0;
  logic [DW-1:0] model [2**AW];
  typedef struct {logic [DW-1:0] data; int at;} exp_t;
  exp_t sbq[$];
  exp_t e;
  logic [DW-1:0] last_data = '0;
  logic prev_valid = 0, mon_en = 0;

  clocked_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(0)) dut (
    .CLK(CLK), .nRST(nRST), .nCE(nCE), .nOE(nOE), .nWE(nWE), .A(A), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_VALID(D_VALID), .LD_VALID(LD_VALID),
    .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!D_VALID && t < 12) begin
      tick();
      t++;
    end
    if (!D_VALID) begin
      total++;
      bad++;
      $display("FAIL %s: D_VALID=%0b required 1 within 12 cycles", name, D_VALID);
    end
  endtask

  task automatic load(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    int t = 0;
    LD_VALID = 1;
    LD_ADDR = ad;
    LD_DATA = d;
    while (!LD_READY && t < 20) begin
      tick();
      t++;
    end
    if (!LD_READY) begin
      total++;
      bad++;
      $display("FAIL ld_timeout: LD_READY=%0b required 1", LD_READY);
    end
    tick();
    LD_VALID = 0;
    model[ad] = d;
  endtask

  task automatic write_op(input int len);
    for (int i = 0; i < len; i++) begin
      nCE = 0;
      nWE = 0;
      A = AW'($urandom);
      D_IN = DW'($urandom);
      tick();
    end
    model[A] = D_IN;
    nWE = 1;
    nCE = 1;
    tick();
    check("wr_pend_ld_ready", LD_READY, 0);
    tick();
    check("wr_ld_ready", LD_READY, 1);
  endtask

  task automatic read_op(input logic [AW-1:0] ad, input bit chg);
    logic [AW-1:0] ad2;
    nCE = 0;
    nOE = 0;
    nWE = 1;
    A = ad;
    sbq.push_back('{model[ad], cyc + 3});
    wait_valid("rd_timeout");
    if (chg) begin
      ad2 = ad ^ AW'($urandom_range(1, 2**AW - 1));
      A = ad2;
      sbq.push_back('{model[ad2], cyc + 3});
      tick(3);
      wait_valid("chg_timeout");
    end
    if ($urandom_range(0, 1) == 1) nOE = 1;
    else nCE = 1;
    tick();
    nCE = 1;
    nOE = 1;
    tick(2);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (D_VALID && !prev_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: D_VALID rose with D_OUT=%0h, no read outstanding", D_OUT);
        end else begin
          e = sbq.pop_front();
          check("sb_data", D_OUT, e.data);
          check("sb_cycle", cyc, e.at);
          last_data = e.data;
        end
      end else if (D_VALID) begin
        check("hold_data", D_OUT, last_data);
      end else begin
        check("dout_zero", D_OUT, 0);
      end
      if (D_VALID) check("valid_oe", D_OE, 1);
      prev_valid = D_VALID;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nCE = 0;
    nOE = 0;
    nWE = 0;
    tick(3);
    check("rst_oe", D_OE, 0);
    check("rst_valid", D_VALID, 0);
    check("rst_ld_ready", LD_READY, 0);
    nRST = 1;
    nCE = 1;
    nOE = 1;
    nWE = 1;
    tick();
    check("rst_release_ld_ready", LD_READY, 1);
    mon_en = 1;
    for (int i = 0; i < 2**AW; i++) load(AW'(i), DW'($urandom));
    load(6'h10, 8'hA5);
    load(6'h11, 8'h5A);
    nCE = 0;
    nOE = 0;
    A = 6'h10;
    sbq.push_back('{8'hA5, cyc + 3});
    tick();
    check("t2_oe_c1", D_OE, 1);
    check("t2_valid_c1", D_VALID, 0);
    tick();
    check("t2_valid_c2", D_VALID, 0);
    tick();
    check("t2_valid_c3", D_VALID, 1);
    check("t2_dout_c3", D_OUT, 8'hA5);
    A = 6'h11;
    sbq.push_back('{8'h5A, cyc + 3});
    tick();
    check("t3_hold_valid", D_VALID, 1);
    check("t3_hold_dout", D_OUT, 8'hA5);
    tick();
    check("t3_lowz_valid", D_VALID, 0);
    check("t3_lowz_oe", D_OE, 1);
    tick();
    check("t3_new_valid", D_VALID, 1);
    check("t3_new_dout", D_OUT, 8'h5A);
    nOE = 1;
    tick();
    check("t5_hz_oe", D_OE, 1);
    check("t5_hz_valid", D_VALID, 0);
    tick();
    check("t5_off_oe", D_OE, 0);
    nCE = 1;
    tick(2);
    nCE = 0;
    nWE = 0;
    A = 6'h20;
    D_IN = 8'h11;
    tick(2);
    D_IN = 8'h22;
    tick(2);
    nWE = 1;
    nOE = 0;
    model[6'h20] = 8'h22;
    sbq.push_back('{8'h22, cyc + 2});
    tick();
    check("t4_pend_ld_ready", LD_READY, 0);
    wait_valid("t4_timeout");
    check("t4_raw_dout", D_OUT, 8'h22);
    nCE = 1;
    nOE = 1;
    tick(2);
    read_op(6'h20, 0);
    nCE = 0;
    nWE = 0;
    A = 6'h21;
    D_IN = ~model[6'h21];
    tick(2);
    nRST = 0;
    tick();
    check("t4_rst_oe", D_OE, 0);
    check("t4_rst_ld_ready", LD_READY, 0);
    nRST = 1;
    nCE = 1;
    nWE = 1;
    tick(2);
    read_op(6'h21, 0);
    check("t6_ready_pre", LD_READY, 1);
    LD_VALID = 1;
    LD_ADDR = 6'h30;
    LD_DATA = 8'h99;
    nCE = 0;
    nWE = 0;
    A = 6'h31;
    D_IN = 8'h44;
    tick();
    check("t6_ready_drop", LD_READY, 0);
    LD_DATA = 8'hEE;
    tick(2);
    nWE = 1;
    nCE = 1;
    LD_VALID = 0;
    model[6'h30] = 8'h99;
    model[6'h31] = 8'h44;
    tick(2);
    read_op(6'h30, 0);
    read_op(6'h31, 0);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: load(AW'($urandom), DW'($urandom));
        1: write_op(int'($urandom_range(1, 4)));
        2: read_op(AW'($urandom), 0);
        default: read_op(AW'($urandom), 1);
      endcase
    end
    tick(3);
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
